// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_checker
//  Description : Two-stage response checker for the 16-bit adder ALU. It
//                recomputes sum and flags, keeps saturating check/error
//                counts, the last mismatch mask, and can halt on first error.
//                Optional build macro ALU_CHK_PARITY_EN enables Parity checks.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_checker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             halt_on_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      X,
   input  logic [15:0]      Y,
   input  logic [15:0]      Z,
   input  logic             Sign,
   input  logic             Zero,
   input  logic             Carry,
   input  logic             Parity,
   input  logic             Overflow,
   output logic [CNT_W-1:0] check_count,
   output logic [CNT_W-1:0] err_count,
   output logic [5:0]       err_mask,
   output logic             err_sticky,
   output logic             halted
);

   localparam logic [0:0]       c_ST_RUN  = 1'b0;
   localparam logic [0:0]       c_ST_HALT = 1'b1;
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

   logic [0:0]  r_state;
   logic [0:0]  w_next_state;
   logic        r_ready;
   logic        w_accept;

   logic        r_s1_valid;
   logic [15:0] r_s1_x;
   logic [15:0] r_s1_y;
   logic [15:0] r_s1_z;
   logic        r_s1_sign;
   logic        r_s1_zero;
   logic        r_s1_carry;
   logic        r_s1_ovf;

   logic [16:0] w_exp_sum;
   logic        w_exp_ovf;
   logic        w_par_err;
   logic [5:0]  w_mask;

   logic        r_s2_valid;
   logic [5:0]  r_s2_mask;
   logic        w_mismatch;

   assign w_accept = in_valid && r_ready;

   // Stage 1: capture the sample; data needs no reset, only the valid does.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (clear) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_x     <= X;
         r_s1_y     <= Y;
         r_s1_z     <= Z;
         r_s1_sign  <= Sign;
         r_s1_zero  <= Zero;
         r_s1_carry <= Carry;
         r_s1_ovf   <= Overflow;
      end
   end

`ifdef ALU_CHK_PARITY_EN
   logic r_s1_parity;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_parity <= Parity;
      end
   end

   assign w_par_err = (r_s1_parity != ~^w_exp_sum[15:0]);
`else
   logic w_unused_parity;

   assign w_unused_parity = Parity;
   assign w_par_err       = 1'b0;
`endif

   assign w_exp_sum = {1'b0, r_s1_x} + {1'b0, r_s1_y};
   assign w_exp_ovf = (r_s1_x[15] == r_s1_y[15]) && (w_exp_sum[15] != r_s1_x[15]);

   // Mask order {Z, S, ZR, CY, P, V}.
   assign w_mask = {(r_s1_z     != w_exp_sum[15:0]),
                    (r_s1_sign  != w_exp_sum[15]),
                    (r_s1_zero  != (w_exp_sum[15:0] == 16'h0000)),
                    (r_s1_carry != w_exp_sum[16]),
                    w_par_err,
                    (r_s1_ovf   != w_exp_ovf)};

   // Stage 2: hold the field mismatch mask for the bookkeeping update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_mask  <= 6'b0;
      end else if (clear) begin
         r_s2_valid <= 1'b0;
         r_s2_mask  <= 6'b0;
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_mask  <= w_mask;
      end
   end

   assign w_mismatch = r_s2_valid && (r_s2_mask != 6'b0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         check_count <= '0;
         err_count   <= '0;
         err_mask    <= 6'b0;
         err_sticky  <= 1'b0;
      end else if (clear) begin
         check_count <= '0;
         err_count   <= '0;
         err_mask    <= 6'b0;
         err_sticky  <= 1'b0;
      end else if (r_s2_valid) begin
         if (check_count != c_CNT_MAX) begin
            check_count <= check_count + c_CNT_ONE;
         end
         if (w_mismatch) begin
            if (err_count != c_CNT_MAX) begin
               err_count <= err_count + c_CNT_ONE;
            end
            err_mask   <= r_s2_mask;
            err_sticky <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_ST_RUN;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ready <= (w_next_state == c_ST_RUN);
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_RUN:  if (w_mismatch && halt_on_err) w_next_state = c_ST_HALT;
         c_ST_HALT: w_next_state = c_ST_HALT;
         default:   w_next_state = c_ST_RUN;
      endcase
      if (clear) begin
         w_next_state = c_ST_RUN;
      end
   end

   always_comb begin
      halted   = (r_state == c_ST_HALT);
      in_ready = r_ready;
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_checker
//  Description : Scoreboard bench for alu_result_checker (CNT_W=16 and 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_result_checker;

   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        halt_on_err = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] X = '0, Y = '0, Z = '0;
   logic        Sign = 1'b0, Zero = 1'b0, Carry = 1'b0, Parity = 1'b0, Overflow = 1'b0;
   logic [CNT_W-1:0] check_count, err_count;
   logic [5:0]  err_mask;
   logic        err_sticky, halted;

   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [1:0]  check_count2, err_count2;
   logic [5:0]  err_mask2;
   logic        err_sticky2, halted2;

   alu_result_checker #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .clear(clear), .halt_on_err(halt_on_err),
      .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .Z(Z), .Sign(Sign), .Zero(Zero), .Carry(Carry),
      .Parity(Parity), .Overflow(Overflow),
      .check_count(check_count), .err_count(err_count), .err_mask(err_mask),
      .err_sticky(err_sticky), .halted(halted)
   );

   alu_result_checker #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .clear(1'b0), .halt_on_err(1'b0),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .X(X), .Y(Y), .Z(Z), .Sign(Sign), .Zero(Zero), .Carry(Carry),
      .Parity(Parity), .Overflow(Overflow),
      .check_count(check_count2), .err_count(err_count2), .err_mask(err_mask2),
      .err_sticky(err_sticky2), .halted(halted2)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [5:0] exp_q[$];
   int         m_cc, m_ec, prev_cc;
   logic [5:0] m_mask;
   logic       m_sticky, m_halted;
   logic       pend_clear = 1'b0;
   logic       rdy_known  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Golden adder result {Z, S, ZR, CY, P, V} from plain integer arithmetic.
   function automatic logic [20:0] ref_out(input logic [15:0] x, input logic [15:0] y);
      int unsigned e;
      int          sx, sy, ss;
      logic [15:0] ez;
      logic        es, ezr, ecy, ep, ev;
      e   = int'(x) + int'(y);
      ez  = 16'(e % 65536);
      sx  = (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
      sy  = (y >= 16'h8000) ? int'(y) - 65536 : int'(y);
      ss  = sx + sy;
      es  = (ez >= 16'h8000);
      ezr = (ez == 16'h0000);
      ecy = (e >= 32'd65536);
      ep  = (($countones(ez) % 2) == 0);
      ev  = (ss > 32767) || (ss < -32768);
      return {ez, es, ezr, ecy, ep, ev};
   endfunction

   function automatic logic [5:0] ref_mask(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic s, input logic zr,
                                           input logic cy, input logic p, input logic v);
      logic [20:0] g;
      logic [5:0]  m;
      g = ref_out(x, y);
      m = {z != g[20:5], s != g[4], zr != g[3], cy != g[2], p != g[1], v != g[0]};
`ifndef ALU_CHK_PARITY_EN
      m[1] = 1'b0;
`endif
      return m;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_cc = 0; m_ec = 0; m_mask = 6'b0; m_sticky = 1'b0; m_halted = 1'b0;
      prev_cc = 0;
   endtask

   // Monitor: pops one expectation per check_count step; looks ahead for accepts.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (rst) begin
            rdy_known  = 1'b0;
            pend_clear = 1'b0;
         end else begin
            if (pend_clear) begin
               model_reset();
               chk("clear_check_count", check_count, 0);
               chk("clear_err_count", err_count, 0);
               chk("clear_err_mask", err_mask, 0);
               chk("clear_err_sticky", err_sticky, 0);
               chk("clear_halted", halted, 0);
            end else if (int'(check_count) != prev_cc) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_compare", check_count, prev_cc);
               end else begin
                  logic [5:0] m;
                  m = exp_q.pop_front();
                  if (m_cc != CNT_MAX) m_cc++;
                  if (m != 6'b0) begin
                     if (m_ec != CNT_MAX) m_ec++;
                     m_mask   = m;
                     m_sticky = 1'b1;
                     if (halt_on_err) m_halted = 1'b1;
                  end
                  chk("check_count", check_count, m_cc);
                  chk("err_count", err_count, m_ec);
                  chk("err_mask", err_mask, m_mask);
                  chk("err_sticky", err_sticky, m_sticky);
                  chk("halted", halted, m_halted);
               end
            end
            prev_cc = int'(check_count);
            if (rdy_known) chk("in_ready", in_ready, !m_halted);
            rdy_known  = 1'b1;
            pend_clear = clear;
            if (!clear && in_valid && in_ready)
               exp_q.push_back(ref_mask(X, Y, Z, Sign, Zero, Carry, Parity, Overflow));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic [15:0] x, input logic [15:0] y, input logic [5:0] flip);
      logic [20:0] g;
      logic [15:0] zf;
      g  = ref_out(x, y);
      zf = flip[5] ? 16'($urandom_range(1, 65535)) : 16'h0000;
      X = x; Y = y; Z = g[20:5] ^ zf;
      Sign = g[4] ^ flip[4]; Zero = g[3] ^ flip[3]; Carry = g[2] ^ flip[2];
      Parity = g[1] ^ flip[1]; Overflow = g[0] ^ flip[0];
   endtask

   task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [5:0] flip);
      set_bus(x, y, flip);
      in_valid = v;
      cyc();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic do_clear();
      in_valid = 1'b0;
      clear    = 1'b1;
      cyc();
      clear    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] halt_mask;
`ifdef ALU_CHK_PARITY_EN
      halt_mask = 6'b000110;
`else
      halt_mask = 6'b000100;
`endif
      // Reset values while reset is held.
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_check_count", check_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_err_mask", err_mask, 0);
      chk("rst_err_sticky", err_sticky, 0);
      chk("rst_halted", halted, 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("post_rst_in_ready", in_ready, 1);

      // Single correct sample.
      drive(1'b1, 16'h8fff, 16'h8000, 6'b0);
      idle(3);
      chk("first_check_count", check_count, 1);
      chk("first_err_count", err_count, 0);
      chk("first_err_sticky", err_sticky, 0);

      // Back-to-back correct samples.
      do_clear();
      drive(1'b1, 16'hfffe, 16'h0002, 6'b0);
      drive(1'b1, 16'haaaa, 16'h5555, 6'b0);
      drive(1'b1, 16'hffff, 16'hffff, 6'b0);
      idle(3);
      chk("b2b_check_count", check_count, 3);
      chk("b2b_err_count", err_count, 0);

      // Randomized traffic with occasional corruption and one clear.
      for (int i = 0; i < 300; i++) begin
         if (i == 150) do_clear();
         drive(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'b0);
      end
      idle(4);

      // Halt on first error; following samples keep in_valid high.
      do_clear();
      halt_on_err = 1'b1;
      drive(1'b1, 16'hffff, 16'hffff, 6'b000110);
      for (int i = 0; i < 6; i++) drive(1'b1, 16'($urandom), 16'($urandom), 6'b0);
      idle(3);
      chk("halt_halted", halted, 1);
      chk("halt_in_ready", in_ready, 0);
      chk("halt_err_count", err_count, 1);
      chk("halt_err_mask", err_mask, halt_mask);
      chk("halt_err_sticky", err_sticky, 1);

      // Leave HALT via clear, then one correct sample.
      do_clear();
      halt_on_err = 1'b0;
      chk("unhalt_in_ready", in_ready, 1);
      chk("unhalt_halted", halted, 0);
      drive(1'b1, 16'h1234, 16'h4321, 6'b0);
      idle(3);
      chk("unhalt_check_count", check_count, 1);

      // Reset while a sample sits in stage 1.
      drive(1'b1, 16'h0001, 16'h0001, 6'b100000);
      in_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_check_count", check_count, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_err_sticky", err_sticky, 0);
      cyc();
      rst = 1'b0;
      idle(4);
      chk("postrst_check_count", check_count, 0);
      chk("postrst_err_count", err_count, 0);
      chk("postrst_in_ready", in_ready, 1);

      // Saturation on the CNT_W=2 instance.
      for (int i = 0; i < 5; i++) begin
         set_bus(16'h0001, 16'h0001, 6'b100000);
         in_valid2 = 1'b1;
         cyc();
      end
      in_valid2 = 1'b0;
      idle(4);
      chk("sat_err_count", err_count2, 3);
      chk("sat_check_count", check_count2, 3);
      chk("sat_err_sticky", err_sticky2, 1);
      chk("sat_err_mask", err_mask2, 6'b100000);
      chk("sat_halted", halted2, 0);
      chk("sat_in_ready", in_ready2, 1);

      // Everything pushed must have been compared.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
      chk("drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable response checker that sits on the output side of the 16-bit adder ALU and consumes each operand pair together with the ALU's result and five flags. It recomputes the expected sum and flags, compares them field by field, and keeps running check and error counts plus a last-mismatch mask. It is the reader for the ALU's result interface and serves as a hardware scoreboard in benches and FPGA self-test builds.

## Interface
Parameters:
- CNT_W, 16, width of the check and error counters (saturating).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of counters, mask and sticky; returns FSM to RUN.
- halt_on_err  input  1  when 1, the first mismatch moves the FSM to HALT.
- in_valid  input  1  sample on X/Y/Z/flags is present.
- in_ready  output  1  checker accepts a sample this cycle.
- X, Y  input  16 each  ALU operands.
- Z  input  16  ALU result.
- Sign, Zero, Carry, Parity, Overflow  input  1 each  ALU flags.
- check_count  output  CNT_W  samples compared.
- err_count  output  CNT_W  samples with at least one mismatch.
- err_mask  output  6  mismatch mask of the most recent failing sample: {Z, S, ZR, CY, P, V}, bit 5 = Z.
- err_sticky  output  1  set on any mismatch since reset/clear.
- halted  output  1  FSM in HALT.

## Operation
- Accept when in_valid && in_ready; the sample is registered into stage 1 (S1).
- Stage 2 (S2): expected sum E = {1'b0,X} + {1'b0,Y} (17 bits). Expected Z = E[15:0]; Carry = E[16]; Sign = E[15]; Zero = (E[15:0] == 0); Overflow = (X[15] == Y[15]) && (E[15] != X[15]); Parity = ~^E[15:0] (1 = even number of ones).
- Compare each field; mask bit set on mismatch. If mask != 0: err_count++, err_mask <= mask, err_sticky <= 1. check_count++ for every compared sample.
- Counters saturate at 2^CNT_W-1; no wrap.
- FSM: RUN (in_ready = 1) -> HALT when a mismatching sample reaches S2 and halt_on_err = 1. HALT (in_ready = 0, halted = 1) -> RUN only on clear. The sample already in S1 when the HALT transition occurs is still compared in the next cycle; no further samples are accepted.
- clear has priority over a simultaneous compare: counters, mask and sticky go to 0 and the in-flight S1 sample is dropped.

## Timing
- Reset values: in_ready 0 while rst is asserted, 1 on the first clock after release; check_count 0, err_count 0, err_mask 0, err_sticky 0, halted 0; S1/S2 valids 0; FSM RUN.
- Latency: a sample accepted at edge N updates the counters/mask at edge N+2, visible after N+2.
- Throughput: one sample per cycle in RUN; in_ready does not depend combinationally on in_valid.
- in_ready falls the cycle after the HALT transition edge (registered).
- Reset asserted mid-pipeline discards S1/S2 contents immediately; no partial counter update.

## Configuration
- ALU_CHK_PARITY_EN defined: Parity is compared and mask bit 1 is live.
- Not defined: the Parity input is ignored, mask bit 1 is tied 0, and the parity tree is not built; all other behaviour is unchanged.

## Test plan
- Reset, then X=8fff Y=8000 with Z=0fff S=0 ZR=0 CY=1 P=1 V=1 -> check_count=1, err_count=0, err_sticky=0 two cycles after acceptance.
- Back-to-back: fffe+0002 (Z=0000 S=0 ZR=1 CY=1 P=1 V=0), AAAA+5555 (Z=FFFF S=1 ZR=0 CY=0 P=1 V=0), FFFF+FFFF (Z=FFFE S=1 ZR=0 CY=1 P=0 V=0) on consecutive cycles -> check_count=3, err_count=0, in_ready held 1.
- Inject FFFF+FFFF with CY=0 and P=1, halt_on_err=1 -> err_count=1, err_mask=6'b000110 (with ALU_CHK_PARITY_EN; 6'b000100 without), err_sticky=1, halted=1, in_ready=0; further in_valid ignored.
- From HALT, pulse clear -> all counters/mask/sticky 0, halted=0, in_ready=1; next correct sample -> check_count=1.
- CNT_W=2, drive 5 bad samples with halt_on_err=0 -> err_count=3 and check_count=3 (saturated), err_sticky=1.
- Assert rst with a sample in S1 -> on release, all outputs at reset values, check_count stays 0.
